// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle shared between the writeback requesters and the
// register file write arbiter. The arbiter takes the slave view; the
// requesters / register file side take the master view.
interface rf_write_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Requester side: flattened, requester i occupies slice i.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  // Register file write port and sweep status.
  logic                          rf_wen;
  logic [ADDR_WIDTH-1:0]         rf_waddr;
  logic [DATA_WIDTH-1:0]         rf_wdata;
  logic                          init_done;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  rf_wen,
    input  rf_waddr,
    input  rf_wdata,
    input  init_done
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output rf_wen,
    output rf_waddr,
    output rf_wdata,
    output init_done
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter.
// After reset it sweeps zeros into registers 1..2^ADDR_WIDTH-1, then
// shares the single write port between NUM_REQ writeback requesters in
// round-robin order. Writes to register 0 are accepted but dropped, so
// register 0 keeps reading as zero.
module rf_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  rf_write_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] CNT_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]        PTR_MOD   = (PTR_W + 1)'(NUM_REQ);

  // State registers and their next-state values.
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
  logic [PTR_W-1:0]      ptr_q,   ptr_d;
  logic                  wen_q,   wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q,  done_d;

  // Grant path.
  logic [PTR_W:0]        cand_s;
  logic                  gnt_found_s;
  logic [PTR_W-1:0]      gnt_idx_s;
  logic [ADDR_WIDTH-1:0] gnt_addr_s;
  logic [DATA_WIDTH-1:0] gnt_data_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic                  run_s;
  logic                  xfer_s;

  assign run_s = (state_q == ST_RUN);

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = ptr_q;
    cand_s      = {1'b0, ptr_q};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (cand_s >= PTR_MOD) begin
        cand_s = cand_s - PTR_MOD;
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && bus.req_valid[cand_s[PTR_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Select the granted requester's address/data and build the one-hot ready.
  always_comb begin
    gnt_addr_s = {ADDR_WIDTH{1'b0}};
    gnt_data_s = {DATA_WIDTH{1'b0}};
    ready_s    = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_s == PTR_W'(i)) begin
        gnt_addr_s = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_data_s = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        ready_s[i] = run_s & gnt_found_s;
      end else begin
        ready_s[i] = 1'b0;
      end
    end
  end

  // A transfer happens whenever ready is offered, since ready only goes to a valid requester.
  assign xfer_s = run_s & gnt_found_s;

  // Next-state logic for the sweep counter, round-robin pointer and write port.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    wen_d   = wen_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    case (state_q)
      ST_INIT: begin
        wen_d   = 1'b1;
        waddr_d = cnt_q;
        wdata_d = {DATA_WIDTH{1'b0}};
        if (cnt_q == CNT_LAST) begin
          // Last register issued: hold the counter rather than wrap.
          state_d = ST_RUN;
          done_d  = 1'b1;
          cnt_d   = cnt_q;
        end else begin
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          // Register 0 is hard zero: accept the request but suppress the write.
          wen_d   = (gnt_addr_s != ADDR_ZERO);
          waddr_d = gnt_addr_s;
          wdata_d = gnt_data_s;
          if (gnt_idx_s == PTR_LAST) begin
            ptr_d = {PTR_W{1'b0}};
          end else begin
            ptr_d = gnt_idx_s + PTR_W'(1);
          end
        end else begin
          wen_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = CNT_FIRST;
        ptr_d   = {PTR_W{1'b0}};
        wen_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State update; reset restarts the sweep and discards any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= CNT_FIRST;
      ptr_q   <= {PTR_W{1'b0}};
      wen_q   <= 1'b0;
      waddr_q <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rf_wen    = wen_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.init_done = done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a driver issues requests and pushes
// the writes a round-robin reference predicts; a monitor pops and compares
// whenever the DUT drives rf_wen.
module tb_rf_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SWEEP_LAST = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  rf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // cycles since the last reset edge
  int mode  = 0;   // 0 idle, 1 fixed all-valid, 2 random

  logic [DW-1:0] rf_seen [32];   // register file as written by the DUT
  logic [DW-1:0] mem_ref [32];   // register file as the reference expects

  bit            pend_v [N];
  int            pend_a [N];
  logic [DW-1:0] pend_d [N];
  int            ptr_m = 0;

  // Cycle counter: cycle k is the k-th cycle after reset release.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Monitor: every cycle check init_done and any write on the RF port.
  initial begin
    for (int i = 0; i < 32; i++) rf_seen[i] = '0;
    forever begin
      @(negedge clk);
      total++;
      if (bus.init_done !== (cyc >= SWEEP_LAST)) begin
        bad++;
        $display("FAIL init_done cyc=%0d got=%b want=%b", cyc, bus.init_done, (cyc >= SWEEP_LAST));
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missing_write cyc=%0d got=none want addr=%0d data=%h at cyc %0d",
                 cyc, exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.rf_wen === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_write cyc=%0d got addr=%0d data=%h want no write",
                   cyc, bus.rf_waddr, bus.rf_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (int'(bus.rf_waddr) != e.addr || bus.rf_wdata !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL write cyc=%0d got addr=%0d data=%h want addr=%0d data=%h cyc=%0d",
                     cyc, bus.rf_waddr, bus.rf_wdata, e.addr, e.data, e.cyc);
          end
        end
        rf_seen[bus.rf_waddr] = bus.rf_wdata;
      end else if (bus.rf_wen !== 1'b0) begin
        total++; bad++;
        $display("FAIL wen_unknown cyc=%0d got=%b want 0/1", cyc, bus.rf_wen);
      end
    end
  end

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i]) begin
        if (mode == 1) begin
          pend_v[i] = 1'b1;
          pend_a[i] = 5 + i;
          pend_d[i] = 32'h0000_000A + DW'(i);
        end else if (mode == 2 && $urandom_range(0, 99) < 50) begin
          pend_v[i] = 1'b1;
          pend_a[i] = int'($urandom_range(0, SWEEP_LAST));
          pend_d[i] = $urandom;
        end
      end else if (mode == 2 && $urandom_range(0, 99) < 8) begin
        pend_v[i] = 1'b0;   // withdrawn before acceptance
      end
    end
  endtask

  // One cycle: drive, check the grant against the reference, record outcome.
  task automatic one_cycle(input bit r);
    bit            was_rst;
    int            g;
    logic [N-1:0]  exp_r;
    was_rst = rst;
    rst = r;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = pend_v[i];
      bus.req_addr[i*AW +: AW] = AW'(pend_a[i]);
      bus.req_data[i*DW +: DW] = pend_d[i];
    end
    #1;
    g = -1;
    if (cyc >= SWEEP_LAST) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr_m + k) % N;
        if (g < 0 && pend_v[i]) g = i;
      end
    end
    exp_r = '0;
    if (g >= 0) exp_r[g] = 1'b1;
    total++;
    if (bus.req_ready !== exp_r) begin
      bad++;
      $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, exp_r);
    end
    if (g >= 0) begin
      if (!r) begin
        if (pend_a[g] != 0) begin
          wr_t e;
          e.addr = pend_a[g]; e.data = pend_d[g]; e.cyc = cyc + 1;
          exp_q.push_back(e);
          mem_ref[pend_a[g]] = pend_d[g];
        end
        ptr_m = (g + 1) % N;
      end
      pend_v[g] = 1'b0;
    end
    if (r) ptr_m = 0;
    if (was_rst && !r) begin
      for (int k = 1; k <= SWEEP_LAST; k++) begin
        wr_t e;
        e.addr = k; e.data = '0; e.cyc = k;
        exp_q.push_back(e);
        mem_ref[k] = '0;
      end
    end
    refill();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem_ref[i] = '0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = 0; pend_d[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    @(negedge clk);
    repeat (3) one_cycle(1'b1);
    // Sweep with no requests, then idle.
    repeat (45) one_cycle(1'b0);
    // Requests held through INIT, then continuous all-valid traffic.
    repeat (2) one_cycle(1'b1);
    mode = 1;
    refill();
    repeat (42) one_cycle(1'b0);
    mode = 0;
    repeat (5) one_cycle(1'b0);
    // Address-0 request.
    pend_v[0] = 1'b1; pend_a[0] = 0; pend_d[0] = 32'hDEAD_BEEF;
    repeat (3) one_cycle(1'b0);
    // Pointer skip: 0 alone, then 2 alone, then 1 alone.
    pend_v[0] = 1'b1; pend_a[0] = 12; pend_d[0] = 32'h1200_0001;
    one_cycle(1'b0);
    pend_v[2] = 1'b1; pend_a[2] = 13; pend_d[2] = 32'h1300_0002;
    one_cycle(1'b0);
    pend_v[1] = 1'b1; pend_a[1] = 14; pend_d[1] = 32'h1400_0003;
    repeat (3) one_cycle(1'b0);
    // Random traffic.
    mode = 2;
    repeat (400) one_cycle(1'b0);
    mode = 0;
    repeat (6) one_cycle(1'b0);
    // Reset in the same cycle as an accepted write to register 9.
    pend_v[1] = 1'b1; pend_a[1] = 9; pend_d[1] = 32'h9999_9999;
    one_cycle(1'b1);
    repeat (40) one_cycle(1'b0);
    mode = 2;
    repeat (200) one_cycle(1'b0);
    mode = 0;
    repeat (10) one_cycle(1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d pending want=0", exp_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (rf_seen[i] !== mem_ref[i]) begin
        bad++;
        $display("FAIL rf_contents reg=%0d got=%h want=%h", i, rf_seen[i], mem_ref[i]);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Sequences and shares the single write port of the 32 x 32-bit register file. After reset it runs a clearing sweep that writes zero to every register from 1 to 2^ADDR_WIDTH-1. It then grants the write port to NUM_REQ writeback requesters in round-robin order using a valid/ready handshake, and drives the register file's wen/waddr/wdata from output registers.

## Interface
- NUM_REQ, 3: number of write requesters (2..8).
- DATA_WIDTH, 32: register data width.
- ADDR_WIDTH, 5: register address width; the sweep covers 1..2^ADDR_WIDTH-1.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- rf_wen  output  1  register file write enable, registered.
- rf_waddr  output  ADDR_WIDTH  register file write address, registered.
- rf_wdata  output  DATA_WIDTH  register file write data, registered.
- init_done  output  1  high once the clearing sweep has been issued, registered.

## Operation
- States: INIT and RUN. Reset forces INIT and sets the sweep counter cnt=1.
- INIT, each cycle:
  - Register rf_wen=1, rf_waddr=cnt, rf_wdata=0; then cnt++.
  - On the edge that issues cnt=2^ADDR_WIDTH-1: go to RUN and set init_done=1.
  - req_ready=0 throughout.
- RUN, grant selection:
  - Round-robin pointer ptr, reset to 0.
  - Grant g = first i in ptr, ptr+1, ... (mod NUM_REQ) with req_valid[i]=1.
  - req_ready[g]=1; every other bit is 0; req_ready=0 when no request is valid.
- RUN, transfer:
  - A transfer occurs when req_valid[g]&req_ready[g].
  - On that edge: rf_wen=1, rf_waddr=req_addr[g], rf_wdata=req_data[g], ptr=(g+1) mod NUM_REQ.
  - No transfer: rf_wen=0; rf_waddr, rf_wdata and ptr hold.
- Address 0: a request to address 0 is accepted (ready, ptr advances) but issues rf_wen=0. Register 0 is never written outside the sweep, and the sweep starts at 1.
- Requesters must hold valid/addr/data stable until accepted. Deasserting valid before acceptance is allowed; nothing is recorded.
- Throughput: one write per cycle in RUN.
- Wrap-around: ptr wraps NUM_REQ-1 -> 0. cnt never wraps, because INIT exits at its maximum.

## Timing
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, init_done=0, req_ready=0, ptr=0, cnt=1, state INIT.
- Sweep: the first edge with rst=0 presents waddr=1. Outputs show waddr=k during cycle k after reset release, k=1..2^ADDR_WIDTH-1.
- init_done rises together with the final sweep write (cycle 31 for ADDR_WIDTH=5). req_ready may assert from that same cycle.
- Latency: accepted in cycle t -> rf_wen/addr/data valid in cycle t+1 -> the register file captures the data at the end of t+1. The data is visible on register file reads in cycle t+2.
- Simultaneous requests: exactly one grant per cycle. A requester that is not granted is served within NUM_REQ-1 further transfers.
- Reset mid-operation:
  - Aborts the current state; the sweep restarts from cnt=1.
  - A write accepted in the cycle rst is high is discarded; rf_wen=0 in the next cycle.
- rst has priority over every other input.

## Test plan
- Reset release, no requests: rf_wen=1 for 31 consecutive cycles with waddr 1..31 and wdata=0, init_done=1 in cycle 31, then rf_wen=0 and all register file reads return 0.
- Requests during INIT: req_valid=3'b111 held from reset release -> req_ready=0 through cycle 30. First grant goes to requester 0 in cycle 31, with its write on outputs in cycle 32.
- Continuous all-valid in RUN, addrs 5/6/7 and data A/B/C -> grants 0,1,2,0,... one per cycle; rf_waddr sequence 5,6,7,5 with matching data.
- Address-0 request, data 0xDEADBEEF -> req_ready=1, ptr advances, rf_wen=0 next cycle, register file rdata for address 0 stays 0.
- Requester 2 only valid after grant to 0 (ptr=1) -> grant 2 immediately, ptr becomes 0; then requester 1 alone is granted in the following cycle.
- rst pulsed for one cycle in the same cycle as an accepted write to reg 9 -> no write to 9, init_done=0, sweep restarts at waddr=1.
